// File: rtl/cp0_excp_unit.sv
// cp0_excp_unit: CP0 register file with precise exception/ERET control, timer and interrupts.
// Revision 1.0
`default_nettype none

module cp0_excp_unit #(
  parameter int          HW_INT_NUM = 6,
  parameter logic [31:0] EXC_ENTRY  = 32'hbfc00380,
  parameter int          COUNT_DIV  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_valid,
  input  logic                  wb_ex,
  input  logic [4:0]            wb_excode,
  input  logic                  wb_bd,
  input  logic [31:0]           wb_pc,
  input  logic [31:0]           wb_badvaddr,
  input  logic                  wb_eret,
  input  logic                  mtc0_we,
  input  logic [7:0]            cp0_addr,
  input  logic [31:0]           cp0_wdata,
  input  logic [HW_INT_NUM-1:0] hw_int,
  output logic [31:0]           cp0_rdata,
  output logic                  flush,
  output logic [31:0]           flush_target,
  output logic                  int_pending,
  output logic [31:0]           epc,
  output logic                  status_exl
);

  localparam logic [7:0] ADDR_BADVADDR = 8'h40;
  localparam logic [7:0] ADDR_COUNT    = 8'h48;
  localparam logic [7:0] ADDR_COMPARE  = 8'h58;
  localparam logic [7:0] ADDR_STATUS   = 8'h60;
  localparam logic [7:0] ADDR_CAUSE    = 8'h68;
  localparam logic [7:0] ADDR_EPC      = 8'h70;
  localparam logic [3:0] DIV_LAST      = 4'(COUNT_DIV - 1);

  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic [7:0]  status_im;
  logic        status_ie;
  logic        exl;
  logic        cause_bd;
  logic        cause_ti;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_excode;
  logic [31:0] epc_reg;
  logic [3:0]  div_cnt;
  logic [5:0]  hw_reg;
  logic [5:0]  hw_pad;
  logic [7:0]  cause_ip;

  logic exc_ev, eret_ev, mtc0_ev, tick, count_wr, compare_wr;

  // Unused hardware lines are tied low so IP bits above HW_INT_NUM+1 read 0.
  if (HW_INT_NUM == 6) begin : g_hw_full
    assign hw_pad = hw_int;
  end else begin : g_hw_part
    assign hw_pad = {{(6 - HW_INT_NUM){1'b0}}, hw_int};
  end

  assign exc_ev     = wb_valid & wb_ex;
  assign eret_ev    = wb_valid & wb_eret & ~wb_ex;
  assign mtc0_ev    = wb_valid & mtc0_we & ~wb_ex;
  assign tick       = (div_cnt == DIV_LAST);
  assign count_wr   = mtc0_ev & (cp0_addr == ADDR_COUNT);
  assign compare_wr = mtc0_ev & (cp0_addr == ADDR_COMPARE);

  assign cause_ip     = {cause_ti | hw_reg[5], hw_reg[4:0], cause_ip_sw};
  assign int_pending  = status_ie & ~exl & (|(cause_ip & status_im));
  assign flush        = ~reset & (exc_ev | eret_ev);
  assign flush_target = exc_ev ? EXC_ENTRY : epc_reg;
  assign epc          = epc_reg;
  assign status_exl   = exl;

  always_ff @(posedge clk) begin
    if (reset) begin
      badvaddr     <= '0;
      count        <= '0;
      compare      <= '0;
      status_im    <= '0;
      status_ie    <= 1'b0;
      exl          <= 1'b0;
      cause_bd     <= 1'b0;
      cause_ti     <= 1'b0;
      cause_ip_sw  <= '0;
      cause_excode <= '0;
      epc_reg      <= '0;
      div_cnt      <= '0;
      hw_reg       <= '0;
    end else begin
      hw_reg <= hw_pad;

      if (count_wr) begin
        count   <= cp0_wdata;
        div_cnt <= '0;
      end else if (tick) begin
        count   <= count + 32'd1;
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 4'd1;
      end

      // A Compare write clears TI even if the timer matches on the same edge.
      if (compare_wr) begin
        compare  <= cp0_wdata;
        cause_ti <= 1'b0;
      end else if (tick && !count_wr && (count + 32'd1 == compare)) begin
        cause_ti <= 1'b1;
      end

      if (mtc0_ev) begin
        case (cp0_addr)
          ADDR_BADVADDR: badvaddr <= cp0_wdata;
          ADDR_STATUS: begin
            status_im <= cp0_wdata[15:8];
            exl       <= cp0_wdata[1];
            status_ie <= cp0_wdata[0];
          end
          ADDR_CAUSE:    cause_ip_sw <= cp0_wdata[9:8];
          ADDR_EPC:      epc_reg     <= cp0_wdata;
          default: ;
        endcase
      end

      if (eret_ev) exl <= 1'b0;

      if (exc_ev) begin
        exl          <= 1'b1;
        cause_excode <= wb_excode;
        if (!exl) begin
          epc_reg  <= wb_bd ? wb_pc - 32'd4 : wb_pc;
          cause_bd <= wb_bd;
        end
        if (wb_excode == 5'd4 || wb_excode == 5'd5) badvaddr <= wb_badvaddr;
      end
    end
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      ADDR_BADVADDR: cp0_rdata = badvaddr;
      ADDR_COUNT:    cp0_rdata = count;
      ADDR_COMPARE:  cp0_rdata = compare;
      ADDR_STATUS:   cp0_rdata = {9'd0, 1'b1, 6'd0, status_im, 6'd0, exl, status_ie};
      ADDR_CAUSE:    cp0_rdata = {cause_bd, cause_ti, 14'd0, cause_ip, 1'b0, cause_excode, 2'b00};
      ADDR_EPC:      cp0_rdata = epc_reg;
      default:       cp0_rdata = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_cp0_excp_unit.sv
// tb_cp0_excp_unit: directed and randomized checks of cp0_excp_unit against a behavioural model.
// Revision 1.0
`default_nettype none

module tb_cp0_excp_unit;

  localparam int          HW_INT_NUM = 6;
  localparam logic [31:0] EXC_ENTRY  = 32'hbfc00380;
  localparam int          COUNT_DIV  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, wb_ex, wb_bd, wb_eret, mtc0_we;
  logic [4:0]  wb_excode;
  logic [31:0] wb_pc, wb_badvaddr, cp0_wdata;
  logic [7:0]  cp0_addr;
  logic [5:0]  hw_int;
  logic [31:0] cp0_rdata, flush_target, epc;
  logic        flush, int_pending, status_exl;

  int n_checks = 0;
  int n_errors = 0;

  cp0_excp_unit #(
    .HW_INT_NUM(HW_INT_NUM),
    .EXC_ENTRY (EXC_ENTRY),
    .COUNT_DIV (COUNT_DIV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_valid    (wb_valid),
    .wb_ex       (wb_ex),
    .wb_excode   (wb_excode),
    .wb_bd       (wb_bd),
    .wb_pc       (wb_pc),
    .wb_badvaddr (wb_badvaddr),
    .wb_eret     (wb_eret),
    .mtc0_we     (mtc0_we),
    .cp0_addr    (cp0_addr),
    .cp0_wdata   (cp0_wdata),
    .hw_int      (hw_int),
    .cp0_rdata   (cp0_rdata),
    .flush       (flush),
    .flush_target(flush_target),
    .int_pending (int_pending),
    .epc         (epc),
    .status_exl  (status_exl)
  );

  always #5 clk = ~clk;

  // Architectural model: Count is derived from the last load value and elapsed cycles.
  logic [31:0] m_badvaddr, m_count_base, m_compare, m_epc;
  int unsigned m_since;
  logic [7:0]  m_im;
  logic        m_ie, m_exl, m_bd, m_ti;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_excode;
  logic [5:0]  m_hw;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_count();
    return m_count_base + 32'(m_since / COUNT_DIV);
  endfunction

  function automatic logic [7:0] m_ip();
    logic [31:0] v;
    v = ((32'(m_ti | m_hw[5])) << 7) | ((32'(m_hw) & 32'h1f) << 2) | 32'(m_ipsw);
    return v[7:0];
  endfunction

  function automatic logic m_pending();
    return m_ie && !m_exl && ((m_ip() & m_im) != 8'h00);
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h40:   return m_badvaddr;
      8'h48:   return m_count();
      8'h58:   return m_compare;
      8'h60:   return 32'h00400000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
      8'h68:   return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip()) << 8) | (32'(m_excode) << 2);
      8'h70:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_badvaddr = 0; m_count_base = 0; m_compare = 0; m_epc = 0; m_since = 0;
    m_im = 0; m_ie = 0; m_exl = 0; m_bd = 0; m_ti = 0; m_ipsw = 0; m_excode = 0; m_hw = 0;
  endtask

  task automatic model_update();
    logic ex, er, mt, inc, wr_cnt, old_exl;
    logic [31:0] old_count;
    if (reset) begin
      model_reset();
      return;
    end
    ex = wb_valid && wb_ex;
    er = wb_valid && wb_eret && !wb_ex;
    mt = wb_valid && mtc0_we && !wb_ex;
    old_exl   = m_exl;
    old_count = m_count();
    inc    = ((m_since + 1) % COUNT_DIV) == 0;
    wr_cnt = mt && cp0_addr == 8'h48;
    if (wr_cnt) begin
      m_count_base = cp0_wdata;
      m_since = 0;
    end else begin
      m_since++;
    end
    if (mt && cp0_addr == 8'h58) begin
      m_compare = cp0_wdata;
      m_ti = 0;
    end else if (!wr_cnt && inc && old_count + 32'd1 == m_compare) begin
      m_ti = 1;
    end
    m_hw = hw_int;
    if (mt && cp0_addr == 8'h60) begin
      m_im = cp0_wdata[15:8];
      m_ie = cp0_wdata[0];
    end
    m_exl = ex ? 1'b1 : er ? 1'b0 : (mt && cp0_addr == 8'h60) ? cp0_wdata[1] : m_exl;
    if (mt && cp0_addr == 8'h68) m_ipsw = cp0_wdata[9:8];
    if (mt && cp0_addr == 8'h40) m_badvaddr = cp0_wdata;
    if (mt && cp0_addr == 8'h70) m_epc = cp0_wdata;
    if (ex) begin
      m_excode = wb_excode;
      if (!old_exl) begin
        m_epc = wb_bd ? wb_pc - 32'd4 : wb_pc;
        m_bd  = wb_bd;
      end
      if (wb_excode == 5'd4 || wb_excode == 5'd5) m_badvaddr = wb_badvaddr;
    end
  endtask

  task automatic idle();
    wb_valid = 0; wb_ex = 0; wb_excode = 0; wb_bd = 0; wb_pc = 0; wb_badvaddr = 0;
    wb_eret = 0; mtc0_we = 0; cp0_wdata = 0;
  endtask

  task automatic run_cycle();
    logic ex, er;
    #1;
    ex = !reset && wb_valid && wb_ex;
    er = !reset && wb_valid && wb_eret && !wb_ex;
    check_val("flush", 32'(flush), 32'(ex || er));
    if (ex || er) check_val("flush_target", flush_target, ex ? EXC_ENTRY : m_epc);
    check_val("rdata", cp0_rdata, m_read(cp0_addr));
    check_val("epc", epc, m_epc);
    check_val("status_exl", 32'(status_exl), 32'(m_exl));
    check_val("int_pending", 32'(int_pending), 32'(m_pending()));
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic peek(input string tag, input logic [7:0] a, input logic [31:0] mask,
                      input logic [31:0] exp);
    cp0_addr = a;
    #1;
    check_val(tag, cp0_rdata & mask, exp);
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    idle();
    wb_valid = 1; mtc0_we = 1; cp0_addr = a; cp0_wdata = d;
    run_cycle();
    idle();
  endtask

  initial begin
    logic [7:0] addrs [7];
    addrs = '{8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h00, 8'h99};
    idle();
    hw_int = 0; cp0_addr = 8'h60; reset = 1;
    model_reset();
    @(negedge clk);
    // Reset wins over a simultaneous exception.
    wb_valid = 1; wb_ex = 1; wb_excode = 4;
    run_cycle();
    run_cycle();
    idle();
    reset = 0;
    peek("rst_status", 8'h60, 32'hffffffff, 32'h00400000);
    peek("rst_cause", 8'h68, 32'hffffffff, 32'h0);
    peek("rst_count", 8'h48, 32'hffffffff, 32'h0);
    run_cycle();

    // Exception in a delay slot.
    wb_valid = 1; wb_ex = 1; wb_bd = 1; wb_pc = 32'hbfc00104; wb_excode = 4;
    wb_badvaddr = 32'h1003;
    #1;
    check_val("ds_flush", 32'(flush), 32'h1);
    check_val("ds_target", flush_target, 32'hbfc00380);
    run_cycle();
    idle();
    peek("ds_epc", 8'h70, 32'hffffffff, 32'hbfc00100);
    peek("ds_cause", 8'h68, 32'hbfffffff, 32'h80000010);
    peek("ds_badvaddr", 8'h40, 32'hffffffff, 32'h1003);
    check_val("ds_exl", 32'(status_exl), 32'h1);
    run_cycle();

    // Nested exception keeps EPC and BD.
    wb_valid = 1; wb_ex = 1; wb_pc = 32'h2000; wb_excode = 8;
    run_cycle();
    idle();
    peek("nest_epc", 8'h70, 32'hffffffff, 32'hbfc00100);
    peek("nest_cause", 8'h68, 32'hbfffffff, 32'h80000020);

    // ERET back to a software-written EPC.
    mtc0(8'h70, 32'h1234);
    wb_valid = 1; wb_eret = 1;
    #1;
    check_val("eret_flush", 32'(flush), 32'h1);
    check_val("eret_target", flush_target, 32'h1234);
    run_cycle();
    idle();
    check_val("eret_exl", 32'(status_exl), 32'h0);

    // Timer interrupt through Compare match.
    mtc0(8'h58, 32'd5);
    mtc0(8'h48, 32'd0);
    repeat (9) run_cycle();
    peek("ti_before", 8'h68, 32'h40000000, 32'h0);
    run_cycle();
    peek("ti_set", 8'h68, 32'h40000000, 32'h40000000);
    mtc0(8'h60, 32'h00408001);
    check_val("ti_pending", 32'(int_pending), 32'h1);
    mtc0(8'h58, 32'h100);
    peek("ti_clear", 8'h68, 32'h40000000, 32'h0);
    check_val("ti_pend_clr", 32'(int_pending), 32'h0);

    // Hardware interrupt line 0.
    mtc0(8'h60, 32'h00000401);
    hw_int = 6'b000001;
    run_cycle();
    peek("hw_ip2", 8'h68, 32'h00000400, 32'h00000400);
    check_val("hw_pending", 32'(int_pending), 32'h1);
    mtc0(8'h60, 32'h00000403);
    check_val("hw_exl_mask", 32'(int_pending), 32'h0);
    hw_int = 0;

    for (int i = 0; i < 600; i++) begin
      idle();
      reset     = ($urandom_range(0, 99) == 0);
      wb_valid  = ($urandom_range(0, 3) != 0);
      wb_ex     = ($urandom_range(0, 7) == 0);
      wb_excode = 5'($urandom_range(0, 31));
      wb_bd     = 1'($urandom);
      wb_pc     = $urandom;
      wb_badvaddr = $urandom;
      wb_eret   = ($urandom_range(0, 7) == 0);
      mtc0_we   = ($urandom_range(0, 2) == 0);
      cp0_addr  = addrs[$urandom_range(0, 6)];
      cp0_wdata = $urandom_range(0, 1) ? 32'($urandom_range(0, 24)) : $urandom;
      if ($urandom_range(0, 9) == 0) hw_int = 6'($urandom);
      run_cycle();
    end
    reset = 0;
    idle();
    run_cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cp0_excp_unit.md
# cp0_excp_unit

Parametrised coprocessor-0 block: holds BadVAddr, Count, Compare, Status, Cause and EPC, and gives the pipeline precise exception and ERET control. It adds a free-running timer, a configurable number of hardware interrupt lines, software interrupts and interrupt detection on top of the previous CP0 generation. It sits beside the writeback stage. Commit, mtc0 and eret information enter from WS; flush/redirect and the pending-interrupt flag go out to all stages.

## Interface
- HW_INT_NUM, 6: number of hardware interrupt inputs, 1..6; drives Cause.IP[HW_INT_NUM+1:2]; unused IP bits read 0.
- EXC_ENTRY, 32'hbfc00380: redirect target on exception.
- COUNT_DIV, 2: Count increments once every COUNT_DIV cycles; legal range 1..16.

- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- wb_valid  in  1  WS holds a valid instruction this cycle.
- wb_ex  in  1  that instruction raises an exception (qualified by wb_valid).
- wb_excode  in  5  ExcCode of the exception.
- wb_bd  in  1  instruction is in a branch delay slot.
- wb_pc  in  32  instruction PC.
- wb_badvaddr  in  32  faulting address for AdEL/AdES.
- wb_eret  in  1  instruction is ERET.
- mtc0_we  in  1  instruction is MTC0.
- cp0_addr  in  8  {rd[4:0], sel[2:0]}.
- cp0_wdata  in  32  MTC0 data.
- hw_int  in  HW_INT_NUM  level-sensitive hardware interrupt lines.
- cp0_rdata  out  32  combinational MFC0 read of cp0_addr.
- flush  out  1  clear all stages this cycle.
- flush_target  out  32  fetch PC after flush.
- int_pending  out  1  interrupt must be taken by the next tagged instruction.
- epc  out  32  current EPC.
- status_exl  out  1  current Status.EXL.

## Operation
- Address map: BadVAddr 0x40, Count 0x48, Compare 0x58, Status 0x60, Cause 0x68, EPC 0x70. Any other address reads 0, and writes to it are ignored.
- Status: BEV bit22 is read-only and reads 1. IM[15:8], EXL[1] and IE[0] are writable. All other bits read 0.
- Cause: BD[31] and TI[30] are read-only. IP[7:2] is hardware-driven. IP[1:0] is software-writable. ExcCode sits in [6:2].
- Commit event: wb_valid & wb_ex. The following take effect:
  - EXL <= 1 and ExcCode <= wb_excode.
  - If EXL was 0: EPC <= wb_bd ? wb_pc-4 : wb_pc, and BD <= wb_bd. If EXL was 1, EPC and BD are held.
  - If wb_excode is 4 or 5: BadVAddr <= wb_badvaddr.
  - flush=1 and flush_target=EXC_ENTRY.
  - Any mtc0_we or wb_eret on the same cycle is ignored.
- ERET event: wb_valid & wb_eret & ~wb_ex. EXL <= 0, flush=1, flush_target=EPC (the register value before the edge).
- MTC0 event: wb_valid & mtc0_we & ~wb_ex. Writes the addressed register.
- Priority for EXL and EPC writes: exception > eret > mtc0.
- Timer:
  - A divider counts 0..COUNT_DIV-1. Count increments (wrapping mod 2^32) when the divider reaches COUNT_DIV-1.
  - An MTC0 to Count loads cp0_wdata, resets the divider to 0, and overrides an increment on the same cycle.
  - TI is set on the increment where Count+1 == Compare.
  - An MTC0 to Compare loads Compare and clears TI. The clear wins over a set on the same cycle.
- Interrupt lines:
  - IP[HW_INT_NUM+1:2] <= hw_int is registered every cycle.
  - IP7 is the OR of TI and hw_int[5] when HW_INT_NUM=6; otherwise IP7 = TI.
- int_pending = IE & ~EXL & |(IP & IM). It is combinational from registers. A taken interrupt commits as an exception with ExcCode 0.

## Timing
- Reset values are all 0, except Status.BEV, which reads 1.
  - Registers zeroed: Status IM/EXL/IE, Cause, EPC, BadVAddr, Count, Compare and the divider.
  - Outputs after reset: flush=0, int_pending=0, cp0_rdata reflects the reset state.
- flush and flush_target are combinational, asserted in the same cycle as the commit or ERET event.
- Every register update is visible on cp0_rdata, epc and status_exl from the cycle after the event.
- A change on hw_int appears in IP one cycle later; int_pending follows in that same cycle.
- A reset asserted mid-timer-count or in the same cycle as an exception wins: all state goes to reset values and flush=0.

## Test plan
- Reset: after reset, read 0x60 -> 0x00400000; read 0x68 -> 0; read 0x48 -> 0; flush=0.
- Exception in delay slot: wb_pc=0xbfc00104, wb_bd=1, excode 4, badvaddr 0x1003 -> same cycle flush=1, target 0xbfc00380. Next cycle EPC=0xbfc00100, Cause=0x80000010, BadVAddr=0x1003, EXL=1.
- Nested exception with EXL=1: wb_pc=0x2000, excode 8 -> EPC unchanged, ExcCode=8.
- ERET: with EPC=0x1234 -> flush=1, target 0x1234; next cycle EXL=0.
- Timer: COUNT_DIV=2; write Compare=5, then Count=0 -> TI=1 after 10 cycles; int_pending=1 when Status=0x00408001. Writing Compare clears TI the next cycle.
- Hardware interrupt: HW_INT_NUM=6, IM=0x04, IE=1, assert hw_int[0] -> Cause.IP2=1 and int_pending=1 one cycle later. With EXL=1, int_pending=0.
